// File: rtl/alarm_pkg.sv
// Purpose: shared state encoding, time limits and wrap/carry helpers for the alarm controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a. ALARM_SNOOZE_EN adds the SNOOZE state to the encoding.
package alarm_pkg;

   localparam logic [6:0] MAX_HOUR = 7'd23;
   localparam logic [6:0] MAX_MIN  = 7'd59;

`ifdef ALARM_SNOOZE_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      RING   = 3'd3,
      SNOOZE = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      RING   = 3'd3
   } state_t;
`endif

   // Hour/minute pair, used for the snooze wake-up time.
   typedef struct packed {
      logic [6:0] h;
      logic [6:0] m;
   } hm_t;

   // Increment with wrap to zero once the field maximum is passed.
   function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] max_v);
      logic [6:0] r;
      if (v >= max_v) r = 7'd0;
      else            r = v + 7'd1;
      return r;
   endfunction

   // Adds a minute offset (0-59) to a time; minute overflow carries into
   // the hour, and the hour wraps past midnight.
   function automatic hm_t add_minutes(input logic [6:0] h, input logic [6:0] m,
                                       input logic [6:0] add);
      hm_t        r;
      logic [7:0] sum;
      sum = {1'b0, m} + {1'b0, add};
      if (sum > {1'b0, MAX_MIN}) begin
         r.m = 7'(sum - 8'd60);
         r.h = inc_wrap(h, MAX_HOUR);
      end else begin
         r.m = sum[6:0];
         r.h = h;
      end
      return r;
   endfunction

endpackage

// File: rtl/blink_gen.sv
// Purpose: square-wave blink generator, toggles every BLINK_DIV cycles; clr restarts the phase.
// Latency: pulse is a register; clr takes effect on the next edge (pulse=0, count=0).
// Backpressure: none, free running.
// Ports: clk, rst (sync active-high), clr (sync phase restart), pulse (blink output).
module blink_gen #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic pulse
);

   localparam int             CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_pulse;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt   <= '0;
         r_pulse <= ~r_pulse;
      end else begin
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   assign pulse = r_pulse;

endmodule

// File: rtl/alarm_controller.sv
// Purpose: alarm clock controller -- set sequence, arming, ringing, optional snooze (ALARM_SNOOZE_EN).
// Latency: every output is registered; a button or trigger is reflected one edge after it is sampled.
// Backpressure: none; buttons and sec_tick are one-cycle pulses sampled every cycle.
// Ports: clk, rst (sync active-high); btn_mode/btn_up/btn_off, sec_tick, h/m/s current time in;
//        ih/im stored alarm, isset armed, clockon display select, ahset/amset edit flags,
//        pulse blink, ring sounding out.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int BLINK_DIV  = 25000000,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_off,
   input  logic       sec_tick,
   input  logic [6:0] h,
   input  logic [6:0] m,
   input  logic [6:0] s,
   output logic [6:0] ih,
   output logic [6:0] im,
   output logic       isset,
   output logic       clockon,
   output logic       ahset,
   output logic       amset,
   output logic       pulse,
   output logic       ring
);

   // Elaboration-time parameter sanity checks.
   if (RING_SEC < 1) begin : g_bad_ring_sec
      $error("RING_SEC must be at least 1");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("BLINK_DIV must be at least 1");
   end
   if (SNOOZE_MIN < 0 || SNOOZE_MIN > 59) begin : g_bad_snooze_min
      $error("SNOOZE_MIN must be within 0..59");
   end

   localparam int              RCW       = $clog2(RING_SEC + 1);
   localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SEC - 1);

   state_t        r_state, w_state_nxt;
   logic [6:0]    r_ih, r_im;
   logic [6:0]    r_ih_sav, r_im_sav;   // alarm as it was when SET_H was entered
   logic          r_isset;
   logic          r_clockon, r_ahset, r_amset, r_ring;
   logic [RCW-1:0] r_ring_cnt;

   // Datapath controls decoded by the FSM.
   logic w_ih_inc, w_im_inc, w_restore, w_isset_tgl, w_isset_set;
   logic w_ring_inc, w_enter_set_h, w_enter_ring;
   logic w_alarm_hit;

   assign w_alarm_hit = sec_tick && r_isset && (h == r_ih) && (m == r_im) && (s == 7'd0);

`ifdef ALARM_SNOOZE_EN
   logic [6:0] r_snz_h, r_snz_m;
   logic       w_snz_load, w_snz_hit;
   hm_t        w_snz_tgt;

   assign w_snz_tgt = add_minutes(h, m, 7'(SNOOZE_MIN));
   assign w_snz_hit = sec_tick && (h == r_snz_h) && (m == r_snz_m) && (s == 7'd0);
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ih_inc    = 1'b0;
      w_im_inc    = 1'b0;
      w_restore   = 1'b0;
      w_isset_tgl = 1'b0;
      w_isset_set = 1'b0;
      w_ring_inc  = 1'b0;
`ifdef ALARM_SNOOZE_EN
      w_snz_load  = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            // mode beats off (isset untouched); off disarms before a trigger can fire
            if (btn_mode)         w_state_nxt = SET_H;
            else if (btn_off)     w_isset_tgl = 1'b1;
            else if (w_alarm_hit) w_state_nxt = RING;
         end
         SET_H: begin
            if (btn_off) begin
               w_state_nxt = IDLE;
               w_restore   = 1'b1;
            end else begin
               w_ih_inc = btn_up;
               if (btn_mode) w_state_nxt = SET_M;
            end
         end
         SET_M: begin
            if (btn_off) begin
               w_state_nxt = IDLE;
               w_restore   = 1'b1;
            end else begin
               w_im_inc = btn_up;
               if (btn_mode) begin
                  w_state_nxt = IDLE;
                  w_isset_set = 1'b1;
               end
            end
         end
         RING: begin
            // btn_mode is deliberately not decoded here
            if (btn_off) begin
               w_state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
            end else if (btn_up) begin
               w_state_nxt = SNOOZE;
               w_snz_load  = 1'b1;
`endif
            end else if (sec_tick) begin
               if (r_ring_cnt == RING_LAST) w_state_nxt = IDLE;
               else                         w_ring_inc  = 1'b1;
            end
         end
`ifdef ALARM_SNOOZE_EN
         SNOOZE: begin
            if (btn_mode)       w_state_nxt = SET_H;
            else if (btn_off)   w_state_nxt = IDLE;
            else if (w_snz_hit) w_state_nxt = RING;
         end
`endif
         default: w_state_nxt = IDLE;
      endcase

      w_enter_set_h = (w_state_nxt == SET_H) && (r_state != SET_H);
      w_enter_ring  = (w_state_nxt == RING)  && (r_state != RING);
   end

   // Alarm value, arming flag and ring-second counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ih       <= 7'd0;
         r_im       <= 7'd0;
         r_ih_sav   <= 7'd0;
         r_im_sav   <= 7'd0;
         r_isset    <= 1'b0;
         r_ring_cnt <= '0;
      end else begin
         if (w_enter_set_h) begin
            r_ih_sav <= r_ih;
            r_im_sav <= r_im;
         end
         if (w_restore) begin
            r_ih <= r_ih_sav;
            r_im <= r_im_sav;
         end else begin
            if (w_ih_inc) r_ih <= inc_wrap(r_ih, MAX_HOUR);
            if (w_im_inc) r_im <= inc_wrap(r_im, MAX_MIN);
         end
         if (w_isset_set)      r_isset <= 1'b1;
         else if (w_isset_tgl) r_isset <= ~r_isset;
         if (w_enter_ring)     r_ring_cnt <= '0;
         else if (w_ring_inc)  r_ring_cnt <= r_ring_cnt + RCW'(1);
      end
   end

`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_snz_h <= 7'd0;
         r_snz_m <= 7'd0;
      end else if (w_snz_load) begin
         r_snz_h <= w_snz_tgt.h;
         r_snz_m <= w_snz_tgt.m;
      end
   end
`endif

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clockon <= 1'b1;
         r_ahset   <= 1'b0;
         r_amset   <= 1'b0;
         r_ring    <= 1'b0;
      end else begin
         r_clockon <= (w_state_nxt != SET_H) && (w_state_nxt != SET_M);
         r_ahset   <= (w_state_nxt == SET_H);
         r_amset   <= (w_state_nxt == SET_M);
         r_ring    <= (w_state_nxt == RING);
      end
   end

   blink_gen #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_enter_set_h),
      .pulse (pulse)
   );

   assign ih      = r_ih;
   assign im      = r_im;
   assign isset   = r_isset;
   assign clockon = r_clockon;
   assign ahset   = r_ahset;
   assign amset   = r_amset;
   assign ring    = r_ring;

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0, btn_up = 1'b0, btn_off = 1'b0, sec_tick = 1'b0;
   logic [6:0] h = 7'd12, m = 7'd0, s = 7'd5;
   logic [6:0] ih, im;
   logic       isset, clockon, ahset, amset, pulse, ring;

   int vectors = 0;
   int fails   = 0;

   always #5 clk = ~clk;

   alarm_controller #(
      .BLINK_DIV  (4),
      .RING_SEC   (3),
      .SNOOZE_MIN (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_mode (btn_mode),
      .btn_up   (btn_up),
      .btn_off  (btn_off),
      .sec_tick (sec_tick),
      .h        (h),
      .m        (m),
      .s        (s),
      .ih       (ih),
      .im       (im),
      .isset    (isset),
      .clockon  (clockon),
      .ahset    (ahset),
      .amset    (amset),
      .pulse    (pulse),
      .ring     (ring)
   );

   // One clock with the given one-cycle inputs; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic md, input logic up, input logic off, input logic tk);
      btn_mode = md; btn_up = up; btn_off = off; sec_tick = tk;
      @(posedge clk);
      #1;
      btn_mode = 1'b0; btn_up = 1'b0; btn_off = 1'b0; sec_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // reset
      idle(2);
      rst = 1'b0;
      chk("rst_ih", ih, 0);
      chk("rst_im", im, 0);
      chk("rst_isset", isset, 0);
      chk("rst_ring", ring, 0);
      chk("rst_pulse", pulse, 0);
      chk("rst_clockon", clockon, 1);
      chk("rst_ahset", ahset, 0);
      chk("rst_amset", amset, 0);

      // blink: half period 4 cycles
      idle(3);
      chk("blink_low", pulse, 0);
      idle(1);
      chk("blink_high", pulse, 1);
      idle(2);
      cyc(1, 0, 0, 0);              // SET_H entry mid-period
      chk("seth_pulse_clr", pulse, 0);
      chk("seth_clockon", clockon, 0);
      chk("seth_ahset", ahset, 1);
      idle(3);
      chk("blink_restart_low", pulse, 0);
      idle(1);
      chk("blink_restart_high", pulse, 1);

      // set sequence 07:30
      repeat (7) cyc(0, 1, 0, 0);
      chk("set_ih7", ih, 7);
      cyc(1, 0, 0, 0);
      chk("setm_amset", amset, 1);
      chk("setm_ahset", ahset, 0);
      repeat (30) cyc(0, 1, 0, 0);
      chk("set_im30", im, 30);
      cyc(1, 0, 0, 0);
      chk("armed_isset", isset, 1);
      chk("armed_clockon", clockon, 1);
      chk("armed_ih", ih, 7);

      // trigger at 07:30:00
      h = 7'd7; m = 7'd30; s = 7'd0;
      cyc(0, 0, 0, 1);
      chk("trig_ring", ring, 1);
      s = 7'd1;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("ring_after2", ring, 1);
      cyc(1, 0, 0, 0);              // mode ignored while ringing
      chk("ring_mode_ign", ring, 1);
      chk("ring_mode_clockon", clockon, 1);
      cyc(0, 0, 0, 1);
      chk("ring_timeout", ring, 0);
      chk("ring_timeout_isset", isset, 1);

      // abort restores 07:30
      cyc(1, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0);
      chk("abort_ih10", ih, 10);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk("abort_im31", im, 31);
      cyc(0, 0, 1, 0);
      chk("abort_ih", ih, 7);
      chk("abort_im", im, 30);
      chk("abort_isset", isset, 1);
      chk("abort_clockon", clockon, 1);

      // wraps
      cyc(1, 0, 0, 0);
      repeat (16) cyc(0, 1, 0, 0);
      chk("ih23", ih, 23);
      cyc(0, 1, 0, 0);
      chk("ih_wrap", ih, 0);
      cyc(1, 0, 0, 0);
      repeat (29) cyc(0, 1, 0, 0);
      chk("im59", im, 59);
      cyc(0, 1, 0, 0);
      chk("im_wrap", im, 0);
      cyc(1, 0, 0, 0);
      chk("wrap_isset", isset, 1);

      // arming toggle and mode/off collision in IDLE
      cyc(0, 0, 1, 0);
      chk("off_disarm", isset, 0);
      cyc(0, 0, 1, 0);
      chk("off_rearm", isset, 1);
      cyc(1, 0, 1, 0);
      chk("mode_off_ahset", ahset, 1);
      chk("mode_off_isset", isset, 1);
      cyc(0, 0, 1, 0);
      chk("mode_off_abort", clockon, 1);

      // off+up while ringing -> IDLE
      h = 7'd0; m = 7'd0; s = 7'd0;
      cyc(0, 0, 0, 1);
      chk("trig2_ring", ring, 1);
      cyc(0, 1, 1, 0);
      chk("offup_ring", ring, 0);
      chk("offup_clockon", clockon, 1);
      m = 7'd5;
      cyc(0, 0, 0, 1);
      chk("offup_not_snooze", ring, 0);

`ifndef ALARM_SNOOZE_EN
      m = 7'd0;
      cyc(0, 0, 0, 1);
      chk("trig3_ring", ring, 1);
      cyc(0, 1, 0, 0);
      chk("up_ignored", ring, 1);
      cyc(0, 0, 1, 0);
      chk("off_silence", ring, 0);
`endif

      // reset mid-ring
      m = 7'd0;
      cyc(0, 0, 0, 1);
      chk("trig4_ring", ring, 1);
      rst = 1'b1;
      cyc(0, 0, 0, 0);
      rst = 1'b0;
      chk("rstring_ring", ring, 0);
      chk("rstring_isset", isset, 0);
      chk("rstring_clockon", clockon, 1);

`ifdef ALARM_SNOOZE_EN
      // snooze across midnight: 23:58 + 5 -> 00:03
      cyc(1, 0, 0, 0);
      repeat (23) cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      repeat (58) cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      h = 7'd23; m = 7'd58; s = 7'd0;
      cyc(0, 0, 0, 1);
      chk("snz_ring", ring, 1);
      cyc(0, 1, 0, 0);
      chk("snz_enter_ring", ring, 0);
      chk("snz_clockon", clockon, 1);
      h = 7'd0; m = 7'd2;
      cyc(0, 0, 0, 1);
      chk("snz_early", ring, 0);
      m = 7'd3;
      cyc(0, 0, 0, 1);
      chk("snz_recur", ring, 1);
      cyc(0, 0, 1, 0);
      chk("snz_off", ring, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
